// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute stage that reads rs1/rs2 from the
// register file over valid/ack ports A and B and hands a bundle to execute.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_*                       decoded instruction in, id_ready back-pressure
//   rd_addr_*, rd_addr_*_valid regfile read requests (registered)
//   rd_data_*, rd_data_*_ack   regfile read data and acks
//   ex_*                       operand bundle out, ex_valid/ex_ready handshake
//   err                        sticky flag: regfile failed to ack in time
module operand_fetch #(
    parameter int OP_W        = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic [31:0]     id_imm,
    input  logic [OP_W-1:0] id_op,
    output logic [4:0]      rd_addr_a,
    output logic [4:0]      rd_addr_b,
    output logic            rd_addr_a_valid,
    output logic            rd_addr_b_valid,
    input  logic [31:0]     rd_data_a,
    input  logic [31:0]     rd_data_b,
    input  logic            rd_data_a_ack,
    input  logic            rd_data_b_ack,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_op1,
    output logic [31:0]     ex_op2,
    output logic [4:0]      ex_rd,
    output logic [31:0]     ex_imm,
    output logic [OP_W-1:0] ex_op,
    output logic            err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      addr_a_q, addr_a_d;
    logic [4:0]      addr_b_q, addr_b_d;
    logic            va_q, va_d;
    logic            vb_q, vb_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     imm_q, imm_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic need_a;
    logic need_b;
    logic accept;
    logic any_ack;

    assign need_a   = id_use_rs1 && (id_rs1 != 5'd0);
    assign need_b   = id_use_rs2 && (id_rs2 != 5'd0);
    assign id_ready = (state_q == IDLE) && !reset;
    assign accept   = id_valid && id_ready;
    assign any_ack  = rd_data_a_ack || rd_data_b_ack;

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        va_d     = va_q;
        vb_d     = vb_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d     = id_rd;
                    imm_d    = id_imm;
                    op_d     = id_op;
                    addr_a_d = id_rs1;
                    addr_b_d = id_rs2;
                    va_d     = need_a;
                    vb_d     = need_b;
                    // Unneeded sources read as zero.
                    op1_d    = '0;
                    op2_d    = '0;
                    cnt_d    = '0;
                    state_d  = (need_a || need_b) ? WAIT : OUT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A port's valid staying high means it is still pending.
                if (va_q && rd_data_a_ack) begin
                    op1_d = rd_data_a;
                    va_d  = 1'b0;
                end
                if (vb_q && rd_data_b_ack) begin
                    op2_d = rd_data_b;
                    vb_d  = 1'b0;
                end
                if (!va_d && !vb_d) begin
                    state_d = OUT;
                end else if (cnt_d == CW'(ACK_TIMEOUT)) begin
                    err_d   = 1'b1;
                    va_d    = 1'b0;
                    vb_d    = 1'b0;
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (ex_ready) begin
                    state_d = any_ack ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                // Let trailing acks die so they cannot match a new request.
                if (!any_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            va_q     <= 1'b0;
            vb_q     <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign rd_addr_a       = addr_a_q;
    assign rd_addr_b       = addr_b_q;
    assign rd_addr_a_valid = va_q;
    assign rd_addr_b_valid = vb_q;
    assign ex_valid        = (state_q == OUT);
    assign ex_op1          = op1_q;
    assign ex_op2          = op2_q;
    assign ex_rd           = rd_q;
    assign ex_imm          = imm_q;
    assign ex_op           = op_q;
    assign err             = err_q;

endmodule
